// File: rtl/updown_counter_param.sv
// Parametrised up/down loadable counter with step size, min/max limits,
// wrap/saturate selection, terminal-count and compare-match pulses, sticky overflow.
module updown_counter_param #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             count_en,
   input  logic             count_up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] min_val,
   input  logic [WIDTH-1:0] max_val,
   input  logic             sat_mode,
   input  logic [WIDTH-1:0] cmp_val,
   input  logic             clr_flags,
   input  logic             drive_out,
   output logic [WIDTH-1:0] count_q,
   output logic [WIDTH-1:0] count_out,
   output logic             tc,
   output logic             match,
   output logic             ovf,
   output logic             cfg_err
);

   localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

   logic [WIDTH:0]   sum_up;
   logic [WIDTH:0]   floor_dn;
   logic             step_evt;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] next_q;
   logic             upd;
   logic             is_load;

   assign cfg_err   = (min_val > max_val);
   assign count_out = (en && drive_out) ? count_q : '0;

   // Limit checks are done one bit wider so a carry past the top of the range
   // is seen as a boundary event rather than silently wrapping.
   assign sum_up   = {1'b0, count_q} + {1'b0, step};
   assign floor_dn = {1'b0, min_val} + {1'b0, step};

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      step_evt = 1'b0;
      step_val = count_q;
      if (count_up) begin
         step_evt = (sum_up > {1'b0, max_val});
         if (!step_evt)     step_val = sum_up[WIDTH-1:0];
         else if (sat_mode) step_val = max_val;
         else               step_val = min_val;
      end else begin
         step_evt = ({1'b0, count_q} < floor_dn);
         if (!step_evt)     step_val = count_q - step;
         else if (sat_mode) step_val = min_val;
         else               step_val = max_val;
      end
   end

   // Load outranks counting; cfg_err or a disabled design freezes the value.
   assign is_load = en && !cfg_err && load;
   assign upd     = en && !cfg_err && (load || count_en);
   assign next_q  = is_load ? load_val : step_val;

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= RESET_Q;
         tc      <= 1'b0;
         match   <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         tc    <= 1'b0;
         match <= 1'b0;
         if (en && !cfg_err) begin
            if (clr_flags) ovf <= 1'b0;
            if (upd) begin
               count_q <= next_q;
               match   <= (next_q == cmp_val) && (next_q != count_q);
               if (!is_load && step_evt) begin
                  tc  <= 1'b1;
                  ovf <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param (WIDTH=8): reset, wrap, saturate,
// priority, compare-match and configuration-error cases.
module tb_updown_counter_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, count_en, count_up, load, sat_mode, clr_flags, drive_out;
   logic [7:0] load_val, step, min_val, max_val, cmp_val;
   logic [7:0] count_q, count_out;
   logic       tc, match, ovf, cfg_err;

   int tests  = 0;
   int failed = 0;

   updown_counter_param #(.WIDTH(8), .RESET_VAL(0)) dut (
      .clk(clk), .rst(rst), .en(en), .count_en(count_en), .count_up(count_up),
      .load(load), .load_val(load_val), .step(step), .min_val(min_val),
      .max_val(max_val), .sat_mode(sat_mode), .cmp_val(cmp_val),
      .clr_flags(clr_flags), .drive_out(drive_out), .count_q(count_q),
      .count_out(count_out), .tc(tc), .match(match), .ovf(ovf), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [7:0] v);
      load = 1'b1; load_val = v;
      tick();
      load = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; count_en = 1'b0; count_up = 1'b1; load = 1'b0;
      sat_mode = 1'b0; clr_flags = 1'b0; drive_out = 1'b1;
      load_val = 8'h00; step = 8'd1; min_val = 8'd0; max_val = 8'd255; cmp_val = 8'hAA;
      #2;
      check("rst_count", count_q, 8'h00);
      check("rst_flags", {tc, match, ovf}, 3'b000);
      #10 rst = 1'b0;
      tick();

      // async reset mid-count
      cmp_val = 8'h37;
      do_load(8'h37);
      check("load_37", count_q, 8'h37);
      check("load_37_match", match, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_count", count_q, 8'h00);
      check("async_rst_flags", {tc, match, ovf}, 3'b000);
      rst = 1'b0; cmp_val = 8'hAA;
      tick();

      // wrap up
      min_val = 8'd2; max_val = 8'd9; step = 8'd3; sat_mode = 1'b0;
      do_load(8'd8);
      check("wrap_load", {count_q, tc}, {8'd8, 1'b0});
      count_en = 1'b1; count_up = 1'b1;
      tick();
      check("wrap_evt", {count_q, tc, ovf}, {8'd2, 1'b1, 1'b1});
      tick();
      check("wrap_next", {count_q, tc, ovf}, {8'd5, 1'b0, 1'b1});
      count_en = 1'b0; clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      check("clr_ovf", ovf, 1'b0);

      // saturate down: 4 < 2+3 is already a boundary event
      sat_mode = 1'b1;
      do_load(8'd4);
      count_en = 1'b1; count_up = 1'b0;
      tick();
      check("sat_dn1", {count_q, tc, ovf}, {8'd2, 1'b1, 1'b1});
      tick();
      check("sat_dn2", {count_q, tc, ovf}, {8'd2, 1'b1, 1'b1});
      count_en = 1'b0; clr_flags = 1'b1;
      tick();
      check("sat_clr", {tc, ovf}, 2'b00);
      count_en = 1'b1;
      tick();
      check("set_beats_clr", {tc, ovf}, 2'b11);
      count_en = 1'b0; clr_flags = 1'b0;

      // load priority over count, enable gating
      min_val = 8'd0; max_val = 8'd255; step = 8'd1; sat_mode = 1'b0;
      count_en = 1'b1; count_up = 1'b1;
      do_load(8'h50);
      check("load_prio", {count_q, tc}, {8'h50, 1'b0});
      en = 1'b0; clr_flags = 1'b1;
      #1;
      check("en0_out", count_out, 8'h00);
      tick();
      check("en0_hold", {count_q, tc, ovf}, {8'h50, 1'b0, 1'b1});
      en = 1'b1; count_en = 1'b0; clr_flags = 1'b0;
      #1;
      check("out_drive", count_out, 8'h50);
      drive_out = 1'b0;
      #1;
      check("out_nodrive", count_out, 8'h00);
      drive_out = 1'b1;

      // compare match
      cmp_val = 8'd6;
      do_load(8'd4);
      count_en = 1'b1;
      tick();
      check("cmp_5", {count_q, match}, {8'd5, 1'b0});
      tick();
      check("cmp_6", {count_q, match}, {8'd6, 1'b1});
      tick();
      check("cmp_7", {count_q, match}, {8'd7, 1'b0});
      count_en = 1'b0;
      do_load(8'd6);
      check("cmp_load6", match, 1'b1);
      do_load(8'd6);
      check("cmp_reload6", match, 1'b0);
      sat_mode = 1'b1; max_val = 8'd6; count_en = 1'b1;
      tick();
      check("cmp_sat_hold", {count_q, tc, match}, {8'd6, 1'b1, 1'b0});
      count_en = 1'b0; sat_mode = 1'b0; cmp_val = 8'hAA;

      // configuration error freezes everything
      min_val = 8'd10; max_val = 8'd5;
      #1;
      check("cfg_err", cfg_err, 1'b1);
      load = 1'b1; load_val = 8'h99; count_en = 1'b1;
      tick();
      load = 1'b0;
      tick();
      check("cfg_freeze", {count_q, tc, match}, {8'd6, 1'b0, 1'b0});

      // full-range wrap from 255
      min_val = 8'd0; max_val = 8'd255; step = 8'd1; count_en = 1'b0; clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      check("cfg_ok", {cfg_err, ovf}, 2'b00);
      do_load(8'd255);
      count_en = 1'b1; count_up = 1'b1;
      tick();
      check("wrap_255", {count_q, tc, ovf}, {8'd0, 1'b1, 1'b1});
      count_en = 1'b0;

      // step=0 pulls out-of-range values back in
      min_val = 8'd2; max_val = 8'd9; step = 8'd0;
      do_load(8'd20);
      count_en = 1'b1;
      tick();
      check("pull_up_wrap", {count_q, tc}, {8'd2, 1'b1});
      tick();
      check("in_range_step0", {count_q, tc}, {8'd2, 1'b0});
      count_en = 1'b0; sat_mode = 1'b1;
      do_load(8'd0);
      count_en = 1'b1; count_up = 1'b0;
      tick();
      check("pull_dn_sat", {count_q, tc}, {8'd2, 1'b1});
      count_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
